// File: rtl/instruction_fetch_stage.sv
// Instruction fetch stage: program counter, instruction memory address drive
// and the IF/ID pipeline register with stall, flush and branch/jump redirect.
// Optional build macro FETCH_ALIGN_CHECK_EN: misaligned redirect targets are
// forced to word alignment and raise a sticky FetchFault.
module instruction_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        Stall,
   input  logic        Flush,
   input  logic        BranchTaken,
   input  logic [31:0] BranchTarget,
   input  logic        Jump,
   input  logic [31:0] JumpTarget,
   input  logic [31:0] Instruction,
   output logic [31:0] Address,
   output logic [31:0] IF_ID_Instruction,
   output logic [31:0] IF_ID_PCPlus4,
   output logic        IF_ID_Valid,
   output logic [31:0] FetchCount,
   output logic        FetchFault
);

   logic [31:0] pc;
   logic [31:0] pc_plus4;
   logic [31:0] pc_next;

   assign Address  = pc;
   assign pc_plus4 = pc + 32'd4;

`ifdef FETCH_ALIGN_CHECK_EN
   logic        redirect;
   logic [31:0] redirect_target;
   logic        misaligned;

   // Next-PC select; redirect targets are word-aligned and flagged when not.
   always_comb begin
      redirect        = 1'b0;
      redirect_target = pc_plus4;
      if (Jump) begin
         redirect        = 1'b1;
         redirect_target = JumpTarget;
      end else if (BranchTaken) begin
         redirect        = 1'b1;
         redirect_target = BranchTarget;
      end
      // Only a redirect that actually loads the PC (no stall) can fault.
      misaligned = !Stall && redirect && (redirect_target[1:0] != 2'b00);
      pc_next    = redirect ? {redirect_target[31:2], 2'b00} : pc_plus4;
   end

   // Sticky misaligned-redirect flag, cleared only by reset.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         FetchFault <= 1'b0;
      else if (misaligned)
         FetchFault <= 1'b1;
   end
`else
   // Next-PC select: Jump over BranchTaken over sequential; targets verbatim.
   always_comb begin
      pc_next = pc_plus4;
      if (Jump)
         pc_next = JumpTarget;
      else if (BranchTaken)
         pc_next = BranchTarget;
   end

   assign FetchFault = 1'b0;
`endif

   // Program counter: held while stalled, otherwise advances to pc_next.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         pc <= RESET_PC;
      else if (!Stall)
         pc <= pc_next;
   end

   // IF/ID register: flush inserts a bubble even under stall.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         IF_ID_Instruction <= NOP_INSTR;
         IF_ID_PCPlus4     <= 32'h0000_0000;
         IF_ID_Valid       <= 1'b0;
      end else if (Flush) begin
         IF_ID_Instruction <= NOP_INSTR;
         IF_ID_PCPlus4     <= 32'h0000_0000;
         IF_ID_Valid       <= 1'b0;
      end else if (!Stall) begin
         IF_ID_Instruction <= Instruction;
         IF_ID_PCPlus4     <= pc_plus4;
         IF_ID_Valid       <= 1'b1;
      end
   end

   // Saturating count of real instructions captured into IF/ID.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         FetchCount <= 32'h0000_0000;
      else if (!Flush && !Stall && (FetchCount != 32'hFFFF_FFFF))
         FetchCount <= FetchCount + 32'd1;
   end

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage; instruction memory is modelled
// as a fixed function of the address so each captured word is traceable.
module tb_instruction_fetch_stage;

   logic        Clk = 1'b0;
   logic        Reset = 1'b1;
   logic        Stall = 1'b0;
   logic        Flush = 1'b0;
   logic        BranchTaken = 1'b0;
   logic [31:0] BranchTarget = 32'h0;
   logic        Jump = 1'b0;
   logic [31:0] JumpTarget = 32'h0;
   logic [31:0] Instruction;
   logic [31:0] Address;
   logic [31:0] IF_ID_Instruction;
   logic [31:0] IF_ID_PCPlus4;
   logic        IF_ID_Valid;
   logic [31:0] FetchCount;
   logic        FetchFault;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] NOP = 32'h0000_0000;

   function automatic logic [31:0] imem(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   assign Instruction = imem(Address);

   always #5 Clk = ~Clk;

   instruction_fetch_stage dut (
      .Clk               (Clk),
      .Reset             (Reset),
      .Stall             (Stall),
      .Flush             (Flush),
      .BranchTaken       (BranchTaken),
      .BranchTarget      (BranchTarget),
      .Jump              (Jump),
      .JumpTarget        (JumpTarget),
      .Instruction       (Instruction),
      .Address           (Address),
      .IF_ID_Instruction (IF_ID_Instruction),
      .IF_ID_PCPlus4     (IF_ID_PCPlus4),
      .IF_ID_Valid       (IF_ID_Valid),
      .FetchCount        (FetchCount),
      .FetchFault        (FetchFault)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_ctl();
      Stall = 1'b0; Flush = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      repeat (2) step();
      checks++; if (Address !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp %h", Address, 32'h0); end
      checks++; if (IF_ID_Instruction !== NOP) begin errors++; $display("FAIL reset_instr got %h exp %h", IF_ID_Instruction, NOP); end
      checks++; if (IF_ID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL reset_pcp4 got %h exp 0", IF_ID_PCPlus4); end
      checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", IF_ID_Valid); end
      checks++; if (FetchCount !== 32'h0) begin errors++; $display("FAIL reset_count got %0d exp 0", FetchCount); end
      checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL reset_fault got %b exp 0", FetchFault); end
      Reset = 1'b0;
   endtask

   task automatic test_sequential();
      for (int i = 1; i <= 3; i++) begin
         step();
         checks++; if (Address !== 32'(4 * i)) begin errors++; $display("FAIL seq_addr%0d got %h exp %h", i, Address, 32'(4 * i)); end
         checks++; if (IF_ID_PCPlus4 !== 32'(4 * i)) begin errors++; $display("FAIL seq_pcp4%0d got %h exp %h", i, IF_ID_PCPlus4, 32'(4 * i)); end
         checks++; if (IF_ID_Instruction !== imem(32'(4 * (i - 1)))) begin errors++; $display("FAIL seq_instr%0d got %h exp %h", i, IF_ID_Instruction, imem(32'(4 * (i - 1)))); end
         checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL seq_valid%0d got %b exp 1", i, IF_ID_Valid); end
      end
      checks++; if (FetchCount !== 32'd3) begin errors++; $display("FAIL seq_count got %0d exp 3", FetchCount); end
   endtask

   task automatic test_stall();
      repeat (4) step();
      checks++; if (Address !== 32'h1C) begin errors++; $display("FAIL stall_pre_addr got %h exp 1c", Address); end
      checks++; if (FetchCount !== 32'd7) begin errors++; $display("FAIL stall_pre_count got %0d exp 7", FetchCount); end
      Stall = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         checks++; if (Address !== 32'h1C) begin errors++; $display("FAIL stall_addr%0d got %h exp 1c", i, Address); end
         checks++; if (IF_ID_PCPlus4 !== 32'h1C) begin errors++; $display("FAIL stall_pcp4%0d got %h exp 1c", i, IF_ID_PCPlus4); end
         checks++; if (IF_ID_Instruction !== imem(32'h18)) begin errors++; $display("FAIL stall_instr%0d got %h exp %h", i, IF_ID_Instruction, imem(32'h18)); end
         checks++; if (FetchCount !== 32'd7) begin errors++; $display("FAIL stall_count%0d got %0d exp 7", i, FetchCount); end
      end
      Stall = 1'b0;
      step();
      checks++; if (Address !== 32'h20) begin errors++; $display("FAIL unstall_addr got %h exp 20", Address); end
      checks++; if (IF_ID_PCPlus4 !== 32'h20) begin errors++; $display("FAIL unstall_pcp4 got %h exp 20", IF_ID_PCPlus4); end
      checks++; if (IF_ID_Instruction !== imem(32'h1C)) begin errors++; $display("FAIL unstall_instr got %h exp %h", IF_ID_Instruction, imem(32'h1C)); end
      checks++; if (FetchCount !== 32'd8) begin errors++; $display("FAIL unstall_count got %0d exp 8", FetchCount); end
   endtask

   task automatic test_branch_flush();
      Reset = 1'b1;
      #2;
      Reset = 1'b0;
      repeat (3) step();
      checks++; if (Address !== 32'h0C) begin errors++; $display("FAIL br_pre_addr got %h exp 0c", Address); end
      BranchTaken = 1'b1; BranchTarget = 32'h68; Flush = 1'b1;
      step();
      clear_ctl();
      checks++; if (Address !== 32'h68) begin errors++; $display("FAIL br_addr got %h exp 68", Address); end
      checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL br_valid got %b exp 0", IF_ID_Valid); end
      checks++; if (IF_ID_Instruction !== NOP) begin errors++; $display("FAIL br_instr got %h exp %h", IF_ID_Instruction, NOP); end
      checks++; if (FetchCount !== 32'd3) begin errors++; $display("FAIL br_count got %0d exp 3", FetchCount); end
      step();
      checks++; if (IF_ID_PCPlus4 !== 32'h6C) begin errors++; $display("FAIL br_next_pcp4 got %h exp 6c", IF_ID_PCPlus4); end
      checks++; if (IF_ID_Instruction !== imem(32'h68)) begin errors++; $display("FAIL br_next_instr got %h exp %h", IF_ID_Instruction, imem(32'h68)); end
      checks++; if (IF_ID_Valid !== 1'b1) begin errors++; $display("FAIL br_next_valid got %b exp 1", IF_ID_Valid); end
      checks++; if (Address !== 32'h6C) begin errors++; $display("FAIL br_next_addr got %h exp 6c", Address); end
   endtask

   task automatic test_priority();
      Jump = 1'b1; JumpTarget = 32'h100; BranchTaken = 1'b1; BranchTarget = 32'h68;
      step();
      checks++; if (Address !== 32'h100) begin errors++; $display("FAIL prio_addr got %h exp 100", Address); end
      checks++; if (IF_ID_PCPlus4 !== 32'h70) begin errors++; $display("FAIL prio_pcp4 got %h exp 70", IF_ID_PCPlus4); end
      JumpTarget = 32'h200; BranchTarget = 32'h300; Stall = 1'b1;
      step();
      clear_ctl();
      checks++; if (Address !== 32'h100) begin errors++; $display("FAIL prio_stall_addr got %h exp 100", Address); end
      checks++; if (IF_ID_PCPlus4 !== 32'h70) begin errors++; $display("FAIL prio_stall_pcp4 got %h exp 70", IF_ID_PCPlus4); end
      checks++; if (FetchCount !== 32'd5) begin errors++; $display("FAIL prio_stall_count got %0d exp 5", FetchCount); end
   endtask

   task automatic test_flush_stall_wrap();
      Flush = 1'b1; Stall = 1'b1;
      step();
      clear_ctl();
      checks++; if (Address !== 32'h100) begin errors++; $display("FAIL fs_addr got %h exp 100", Address); end
      checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL fs_valid got %b exp 0", IF_ID_Valid); end
      checks++; if (IF_ID_Instruction !== NOP) begin errors++; $display("FAIL fs_instr got %h exp %h", IF_ID_Instruction, NOP); end
      checks++; if (FetchCount !== 32'd5) begin errors++; $display("FAIL fs_count got %0d exp 5", FetchCount); end
      Jump = 1'b1; JumpTarget = 32'hFFFF_FFFC;
      step();
      clear_ctl();
      checks++; if (Address !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pre_addr got %h exp fffffffc", Address); end
      checks++; if (IF_ID_PCPlus4 !== 32'h104) begin errors++; $display("FAIL wrap_pre_pcp4 got %h exp 104", IF_ID_PCPlus4); end
      step();
      checks++; if (Address !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h exp 0", Address); end
      checks++; if (IF_ID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL wrap_pcp4 got %h exp 0", IF_ID_PCPlus4); end
      checks++; if (IF_ID_Instruction !== imem(32'hFFFF_FFFC)) begin errors++; $display("FAIL wrap_instr got %h exp %h", IF_ID_Instruction, imem(32'hFFFF_FFFC)); end
      checks++; if (FetchCount !== 32'd7) begin errors++; $display("FAIL wrap_count got %0d exp 7", FetchCount); end
   endtask

   task automatic test_async_reset();
      step();
      #2;
      Reset = 1'b1;
      #1;
      checks++; if (Address !== 32'h0) begin errors++; $display("FAIL areset_addr got %h exp 0", Address); end
      checks++; if (IF_ID_Valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b exp 0", IF_ID_Valid); end
      checks++; if (IF_ID_Instruction !== NOP) begin errors++; $display("FAIL areset_instr got %h exp %h", IF_ID_Instruction, NOP); end
      checks++; if (IF_ID_PCPlus4 !== 32'h0) begin errors++; $display("FAIL areset_pcp4 got %h exp 0", IF_ID_PCPlus4); end
      checks++; if (FetchCount !== 32'h0) begin errors++; $display("FAIL areset_count got %0d exp 0", FetchCount); end
      Reset = 1'b0;
      #1;
      step();
      checks++; if (Address !== 32'h4) begin errors++; $display("FAIL areset_run_addr got %h exp 4", Address); end
      checks++; if (FetchCount !== 32'd1) begin errors++; $display("FAIL areset_run_count got %0d exp 1", FetchCount); end
   endtask

   task automatic test_align();
      // Misaligned branch loses to an aligned jump: no fault.
      Jump = 1'b1; JumpTarget = 32'h100; BranchTaken = 1'b1; BranchTarget = 32'h66;
      step();
      clear_ctl();
      checks++; if (Address !== 32'h100) begin errors++; $display("FAIL al_prio_addr got %h exp 100", Address); end
      checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL al_prio_fault got %b exp 0", FetchFault); end
      // Misaligned jump under stall is not taken: no fault.
      Jump = 1'b1; JumpTarget = 32'h66; Stall = 1'b1;
      step();
      Stall = 1'b0;
      checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL al_stall_fault got %b exp 0", FetchFault); end
      step();
      clear_ctl();
`ifdef FETCH_ALIGN_CHECK_EN
      checks++; if (Address !== 32'h64) begin errors++; $display("FAIL al_addr got %h exp 64", Address); end
      checks++; if (FetchFault !== 1'b1) begin errors++; $display("FAIL al_fault got %b exp 1", FetchFault); end
      step();
      checks++; if (Address !== 32'h68) begin errors++; $display("FAIL al_next_addr got %h exp 68", Address); end
      checks++; if (FetchFault !== 1'b1) begin errors++; $display("FAIL al_sticky got %b exp 1", FetchFault); end
`else
      checks++; if (Address !== 32'h66) begin errors++; $display("FAIL al_addr got %h exp 66", Address); end
      checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL al_fault got %b exp 0", FetchFault); end
      step();
      checks++; if (Address !== 32'h6A) begin errors++; $display("FAIL al_next_addr got %h exp 6a", Address); end
      checks++; if (FetchFault !== 1'b0) begin errors++; $display("FAIL al_sticky got %b exp 0", FetchFault); end
`endif
   endtask

   initial begin
      test_reset();
      test_sequential();
      test_stall();
      test_branch_flush();
      test_priority();
      test_flush_stall_wrap();
      test_async_reset();
      test_align();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
